// File: rtl/ifid_hazard_ctrl_if.sv
// Control bundle between the pipeline datapath and the hazard controller.
// master: controller side (reads hazard inputs, drives enables); slave: datapath side.
interface ifid_hazard_ctrl_if #(
  parameter int REG_W = 4,
  parameter int CNT_W = 16
);
  logic [REG_W-1:0] ifid_rs;
  logic [REG_W-1:0] ifid_rt;
  logic             ifid_uses_rs;
  logic             ifid_uses_rt;
  logic             ifid_halt;
  logic             idex_memread;
  logic [REG_W-1:0] idex_rd;
  logic             branch_taken;
  logic             imem_stall;
  logic             dmem_stall;
  logic             pc_wen;
  logic             ifid_wen;
  logic             ifid_flush;
  logic             idex_bubble;
  logic             idex_wen;
  logic             exmem_wen;
  logic             memwb_wen;
  logic             halted;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    input  ifid_rs, ifid_rt, ifid_uses_rs, ifid_uses_rt,
    input  ifid_halt, idex_memread, idex_rd,
    input  branch_taken, imem_stall, dmem_stall,
    output pc_wen, ifid_wen, ifid_flush, idex_bubble,
    output idex_wen, exmem_wen, memwb_wen,
    output halted, stall_cnt
  );

  modport slave (
    output ifid_rs, ifid_rt, ifid_uses_rs, ifid_uses_rt,
    output ifid_halt, idex_memread, idex_rd,
    output branch_taken, imem_stall, dmem_stall,
    input  pc_wen, ifid_wen, ifid_flush, idex_bubble,
    input  idex_wen, exmem_wen, memwb_wen,
    input  halted, stall_cnt
  );
endinterface

// File: rtl/ifid_hazard_ctrl.sv
// Pipeline sequencing controller: PC/IF-ID/ID-EX/EX-MEM/MEM-WB enables,
// flush and bubble for load-use, imem/dmem stalls, branches and halt drain.
// Ports: clk, rst (sync, active-low), bus (ifid_hazard_ctrl_if.master).
module ifid_hazard_ctrl #(
  parameter int REG_W        = 4,
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  ifid_hazard_ctrl_if.master    bus
);

  localparam int DW = $clog2(DRAIN_CYCLES + 1);
  localparam logic [DW-1:0] DRAIN_LD = DW'(DRAIN_CYCLES);

  typedef enum logic [1:0] {
    S_RUN,
    S_MEM_WAIT,
    S_DRAIN,
    S_HALTED
  } state_t;

  state_t           r_state, r_ret;
  state_t           w_eff, w_nxt_state, w_nxt_ret;
  logic [DW-1:0]    r_drain, w_nxt_drain;
  logic [CNT_W-1:0] r_cnt;

  logic [REG_W-1:0] w_rs, w_rt, w_rd;
  logic w_luh, w_cnt_inc;
  logic w_pc, w_ifw, w_fl, w_bub, w_dw, w_halted;

  assign w_rs = bus.ifid_rs;
  assign w_rt = bus.ifid_rt;
  assign w_rd = bus.idex_rd;

  assign w_luh = bus.idex_memread && (w_rd != '0) &&
    ((bus.ifid_uses_rs && (w_rs == w_rd)) ||
     (bus.ifid_uses_rt && (w_rt == w_rd)));

  // Leaving MEM_WAIT takes effect in the same cycle: the
  // release cycle is judged by the return state's rules.
  assign w_eff = (r_state == S_MEM_WAIT && !bus.dmem_stall) ?
                 r_ret : r_state;

  always_comb begin
    w_pc        = 1'b0;
    w_ifw       = 1'b0;
    w_fl        = 1'b0;
    w_bub       = 1'b0;
    w_dw        = 1'b0;
    w_halted    = 1'b0;
    w_nxt_state = w_eff;
    w_nxt_ret   = r_ret;
    w_nxt_drain = r_drain;
    unique case (w_eff)
      S_RUN: begin
        if (bus.dmem_stall) begin
          w_nxt_state = S_MEM_WAIT;
          w_nxt_ret   = S_RUN;
        end else if (bus.imem_stall || w_luh) begin
          w_bub = 1'b1;
          w_dw  = 1'b1;
        end else if (bus.branch_taken) begin
          w_pc  = 1'b1;
          w_ifw = 1'b1;
          w_fl  = 1'b1;
          w_dw  = 1'b1;
        end else if (bus.ifid_halt) begin
          w_ifw       = 1'b1;
          w_fl        = 1'b1;
          w_dw        = 1'b1;
          w_nxt_drain = DRAIN_LD;
          w_nxt_state = S_DRAIN;
        end else begin
          w_pc  = 1'b1;
          w_ifw = 1'b1;
          w_dw  = 1'b1;
        end
      end
      S_MEM_WAIT: begin
      end
      S_DRAIN: begin
        if (bus.dmem_stall) begin
          w_nxt_state = S_MEM_WAIT;
          w_nxt_ret   = S_DRAIN;
        end else begin
          w_ifw       = 1'b1;
          w_fl        = 1'b1;
          w_dw        = 1'b1;
          w_nxt_drain = r_drain - DW'(1);
          if (r_drain <= DW'(1))
            w_nxt_state = S_HALTED;
        end
      end
      S_HALTED: begin
        w_halted = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Only front-end stalls count: DRAIN/HALTED hold the PC by design.
  assign w_cnt_inc = !w_pc &&
    (r_state == S_RUN || r_state == S_MEM_WAIT);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_RUN;
      r_ret   <= S_RUN;
      r_drain <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_nxt_state;
      r_ret   <= w_nxt_ret;
      r_drain <= w_nxt_drain;
      if (w_cnt_inc && (r_cnt != '1))
        r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign bus.pc_wen      = rst & w_pc;
  assign bus.ifid_wen    = rst & w_ifw;
  assign bus.ifid_flush  = rst & w_fl;
  assign bus.idex_bubble = rst & w_bub;
  assign bus.idex_wen    = rst & w_dw;
  assign bus.exmem_wen   = rst & w_dw;
  assign bus.memwb_wen   = rst & w_dw;
  assign bus.halted      = rst & w_halted;
  assign bus.stall_cnt   = rst ? r_cnt : '0;

endmodule

// File: tb/tb_ifid_hazard_ctrl.sv
// Self-checking bench for ifid_hazard_ctrl: directed plan
// followed by random stimulus against a behavioural model.
module tb_ifid_hazard_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ifid_hazard_ctrl_if #(.REG_W(4), .CNT_W(16)) bus ();

  ifid_hazard_ctrl #(
    .REG_W(4), .DRAIN_CYCLES(3), .CNT_W(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // model state
  bit m_halted   = 0;
  bit m_draining = 0;
  bit m_wait     = 0;
  int m_left     = 0;
  int m_cnt      = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input bit [3:0] rs, input bit [3:0] rt,
                        input bit urs, input bit urt,
                        input bit hlt, input bit mr,
                        input bit [3:0] rd, input bit br,
                        input bit im, input bit dm);
    bus.ifid_rs      = rs;
    bus.ifid_rt      = rt;
    bus.ifid_uses_rs = urs;
    bus.ifid_uses_rt = urt;
    bus.ifid_halt    = hlt;
    bus.idex_memread = mr;
    bus.idex_rd      = rd;
    bus.branch_taken = br;
    bus.imem_stall   = im;
    bus.dmem_stall   = dm;
  endtask

  task automatic idle();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // One clock: compare at negedge, advance model, return just after posedge.
  task automatic tick();
    logic [7:0] exp;
    logic [7:0] obs;
    bit luh;
    bit run_halt;
    @(negedge clk);
    luh = bus.idex_memread && bus.idex_rd != 0 &&
          ((bus.ifid_uses_rs && bus.ifid_rs == bus.idex_rd) ||
           (bus.ifid_uses_rt && bus.ifid_rt == bus.idex_rd));
    run_halt = 0;
    // {pc,ifid_wen,flush,bubble,idex,exmem,memwb,halted}
    if (!rst)                  exp = 8'b0000_0000;
    else if (m_halted)         exp = 8'b0000_0001;
    else if (bus.dmem_stall)   exp = 8'b0000_0000;
    else if (m_draining)       exp = 8'b0110_1110;
    else if (bus.imem_stall || luh) exp = 8'b0001_1110;
    else if (bus.branch_taken) exp = 8'b1110_1110;
    else if (bus.ifid_halt) begin
      exp = 8'b0110_1110;
      run_halt = 1;
    end else                   exp = 8'b1100_1110;
    obs = {bus.pc_wen, bus.ifid_wen, bus.ifid_flush,
           bus.idex_bubble, bus.idex_wen, bus.exmem_wen,
           bus.memwb_wen, bus.halted};
    chk("ctl", 32'(obs), 32'(exp));
    chk("cnt", 32'(bus.stall_cnt), rst ? 32'(m_cnt) : 32'd0);
    if (!rst) begin
      m_halted = 0; m_draining = 0; m_wait = 0;
      m_left = 0; m_cnt = 0;
    end else if (!m_halted) begin
      if (!exp[7] && (!m_draining || m_wait) && m_cnt < 65535)
        m_cnt++;
      if (bus.dmem_stall) begin
        m_wait = 1;
      end else begin
        m_wait = 0;
        if (m_draining) begin
          m_left--;
          if (m_left == 0) begin
            m_draining = 0;
            m_halted   = 1;
          end
        end else if (run_halt) begin
          m_draining = 1;
          m_left     = 3;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    // 1. reset with all inputs high
    rst = 0;
    set_in(4'hF, 4'hF, 1, 1, 1, 1, 4'hF, 1, 1, 1);
    tick(); tick();
    rst = 1; idle();
    tick(); tick();

    // 2. load-use, then same with rd=0
    set_in(0, 5, 0, 1, 0, 1, 5, 0, 0, 0);
    tick();
    chk("luh_cnt", 32'(bus.stall_cnt), 32'd1);
    idle(); tick();
    set_in(0, 0, 0, 1, 0, 1, 0, 0, 0, 0);
    tick();
    idle(); tick();

    // 3. branch under imem stall, then branch alone
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    tick();
    idle(); tick();

    // 4. dmem stall 4 cycles
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    repeat (4) tick();
    idle(); tick();
    chk("dmem_cnt", 32'(bus.stall_cnt), 32'd6);

    // 5a. plain halt drain
    set_in(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    tick();
    idle();
    repeat (3) tick();
    chk("halt_t4", 32'(bus.halted), 32'd1);
    tick(); tick();

    // 5b. halt drain with dmem stall at t+2 for 2 cycles
    rst = 0; tick(); rst = 1;
    set_in(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    tick();
    idle(); tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    tick(); tick();
    idle(); tick(); tick();
    chk("halt_t6", 32'(bus.halted), 32'd1);

    // 6. saturation, then reset while draining
    rst = 0; tick(); rst = 1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    repeat (65540) tick();
    chk("sat", 32'(bus.stall_cnt), 32'hFFFF);
    idle(); tick();
    set_in(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    tick();
    idle(); tick();
    rst = 0; tick(); rst = 1;
    tick();
    chk("rst_drain_cnt", 32'(bus.stall_cnt), 32'd0);
    chk("rst_drain_halt", 32'(bus.halted), 32'd0);

    // random phase
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 39) != 0);
      set_in(4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             $urandom_range(0, 19) == 0, $urandom_range(0, 2) == 0,
             4'($urandom_range(0, 3)), $urandom_range(0, 3) == 0,
             $urandom_range(0, 4) == 0, $urandom_range(0, 7) == 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ifid_hazard_ctrl.md
Name: ifid_hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage CPU.
- Generates write-enable, flush and bubble controls for the PC, the IF/ID register and the downstream ID/EX, EX/MEM and MEM/WB registers.
- Resolves load-use hazards, instruction-memory and data-memory stalls, ID-stage taken branches and halt drain.
- Sits beside the IF/ID register and drives its wen and flush inputs.

Parameters:
- REG_W, 4, register-specifier width.
- DRAIN_CYCLES, 3, cycles after halt leaves ID until the pipeline is empty (EX, MEM, WB).
- CNT_W, 16, stall-counter width.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  synchronous reset, active-low (0 = reset).
- ifid_rs  input  REG_W  rs field of the instruction in ID.
- ifid_rt  input  REG_W  rt field of the instruction in ID.
- ifid_uses_rs  input  1  ID instruction reads rs.
- ifid_uses_rt  input  1  ID instruction reads rt.
- ifid_halt  input  1  ID instruction is HLT.
- idex_memread  input  1  EX instruction is a load.
- idex_rd  input  REG_W  destination register of the EX instruction.
- branch_taken  input  1  branch/jump resolved taken in ID this cycle.
- imem_stall  input  1  instruction memory is not ready.
- dmem_stall  input  1  data memory is not ready.
- pc_wen  output  1  PC register write enable.
- ifid_wen  output  1  IF/ID write enable.
- ifid_flush  output  1  IF/ID loads a NOP instead of fetched data; only asserted when ifid_wen=1.
- idex_bubble  output  1  ID/EX loads a NOP; controls forced to 0.
- idex_wen  output  1  ID/EX write enable.
- exmem_wen  output  1  EX/MEM write enable.
- memwb_wen  output  1  MEM/WB write enable.
- halted  output  1  pipeline has fully drained after HLT.
- stall_cnt  output  CNT_W  saturating count of front-end stall cycles.

Behaviour:
- Registered state: FSM state, drain counter, return state, stall_cnt. Outputs are combinational from state and the current inputs.
- Reset (rst=0 at posedge):
  - state goes to RUN, drain counter to 0, stall_cnt to 0.
  - While rst=0, every output is 0.
- States: RUN, MEM_WAIT, DRAIN, HALTED.
- Load-use hazard (luh), all conditions required:
  - idex_memread=1
  - idex_rd != 0
  - (ifid_uses_rs and ifid_rs == idex_rd) or (ifid_uses_rt and ifid_rt == idex_rd)
- Per-cycle priority in RUN, highest first:
  1. dmem_stall: all wens=0, flush=0, bubble=0. Save return=RUN; go to MEM_WAIT.
  2. imem_stall: pc_wen=0, ifid_wen=0, idex_bubble=1, other wens=1. branch_taken and ifid_halt are ignored this cycle; they are re-evaluated once IF/ID advances.
  3. luh: pc_wen=0, ifid_wen=0, idex_bubble=1, other wens=1. This gives a 1-cycle stall, because the bubble clears idex_memread on the next cycle. branch_taken is ignored this cycle.
  4. branch_taken: all wens=1, ifid_flush=1 (squashes the wrong-path fetch).
  5. ifid_halt: pc_wen=0, ifid_wen=1, ifid_flush=1, other wens=1. The halt bit travels on into ID/EX. Load drain counter with DRAIN_CYCLES; go to DRAIN.
  6. Otherwise: all wens=1, flush=0, bubble=0.
- MEM_WAIT:
  - While dmem_stall=1: all wens=0; the drain counter is frozen.
  - On dmem_stall=0: go to the return state; that same cycle is evaluated with the return state's rules.
- DRAIN:
  - pc_wen=0, ifid_wen=1, ifid_flush=1, idex/exmem/memwb wens=1.
  - Each cycle with dmem_stall=0: decrement the counter. When the counter reaches 0 (the decrement from 1), go to HALTED at the next edge.
  - dmem_stall in DRAIN: all wens=0, return=DRAIN, go to MEM_WAIT.
  - imem_stall, branch_taken and luh have no effect in DRAIN.
- HALTED: all wens=0, flush=0, bubble=0, halted=1. Exited only by reset.
- stall_cnt: increments on each cycle where state is RUN or MEM_WAIT and pc_wen=0. Saturates at 2^CNT_W-1.
- Reset mid-operation: any state returns to RUN next cycle; counters clear. Reset overrides all inputs.

Test Plan:
1. Reset: rst=0 for 2 cycles with all inputs=1 -> all outputs 0, stall_cnt=0. After rst=1 with idle inputs -> all wens=1, halted=0.
2. Load-use: idex_memread=1, idex_rd=5, ifid_uses_rt=1, ifid_rt=5 for one cycle -> that cycle pc_wen=0, ifid_wen=0, idex_bubble=1; stall_cnt=1. Same stimulus with idex_rd=0 -> no stall.
3. Branch vs stall: branch_taken=1 with imem_stall=1 -> pc_wen=0, idex_bubble=1, ifid_flush=0. Next cycle imem_stall=0, branch_taken=1 -> ifid_flush=1, pc_wen=1.
4. Dmem stall: dmem_stall=1 for 4 cycles in RUN -> all wens=0 for 4 cycles, stall_cnt +4. Resumes RUN with wens=1 on the first low cycle.
5. Halt drain: ifid_halt=1 at cycle t -> pc_wen=0 from t; DRAIN for t+1..t+3; halted=1 from t+4. With dmem_stall=1 at t+2 for 2 cycles -> halted=1 from t+6.
6. Saturation and reset: force 65540 stall cycles -> stall_cnt=0xFFFF held. Then rst=0 in DRAIN -> RUN, stall_cnt=0, halted=0.
